// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with majority-vote bit decisions,
// parity/framing/break detection and a first-word-fall-through FIFO.
`timescale 1ns/1ps
module uart_rx_ovs #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVS        = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 2,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rx,
  output logic [DATA_BITS-1:0]        m_data,
  output logic                        m_err_parity,
  output logic                        m_err_frame,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        overrun,
  output logic                        break_det,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int DIV = CLK_FREQ / (BAUD * OVS);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVS);
  localparam int BW  = 4;
  localparam int AW  = $clog2(FIFO_DEPTH);

  if (DIV < 1) begin : g_bad_div
    $error("uart_rx_ovs: CLK_FREQ/(BAUD*OVS) must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY_ST, STOP, BRK_WAIT
  } state_t;

  typedef struct packed {
    logic                 ferr;
    logic                 perr;
    logic [DATA_BITS-1:0] data;
  } ent_t;

  logic rx_meta, rxs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  logic [CW-1:0] pcnt;
  logic          tick;

  assign tick = (pcnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + 1'b1;
  end

  state_t               state, state_n;
  logic [SW-1:0]        sub;
  logic [BW-1:0]        bcnt;
  logic                 sa, sb, maj;
  logic                 dec, last;
  logic [DATA_BITS-1:0] dsh;
  logic                 par_bit, ferr;
  logic                 perr, frame_bad, is_brk;
  logic                 push, brk;
  logic                 wr_en;
  ent_t                 wr_ent;

  assign dec  = tick && (sub == SW'(OVS/2 + 1));
  assign last = tick && (sub == SW'(OVS - 1));
  assign maj  = (sa & sb) | (sa & rxs) | (sb & rxs);

  assign perr = (PARITY == 1) ? ~(^{dsh, par_bit}) :
                (PARITY == 2) ?  (^{dsh, par_bit}) : 1'b0;
  assign frame_bad = ferr | ~maj;
  assign is_brk    = frame_bad && (dsh == '0) && !par_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    push    = 1'b0;
    brk     = 1'b0;
    unique case (state)
      IDLE:
        if (tick && !rxs) state_n = START;
      START:
        if (dec && maj) state_n = IDLE;
        else if (last)  state_n = DATA;
      DATA:
        if (last && bcnt == BW'(DATA_BITS - 1))
          state_n = (PARITY != 0) ? PARITY_ST : STOP;
      PARITY_ST:
        if (last) state_n = STOP;
      STOP:
        if (dec && bcnt == BW'(STOP_BITS - 1)) begin
          if (is_brk) begin
            brk     = 1'b1;
            state_n = BRK_WAIT;
          end else begin
            push    = 1'b1;
            state_n = IDLE;
          end
        end
      BRK_WAIT:
        if (tick && rxs) state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  // sub holds the index of the tick being processed in the current bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sub       <= '0;
      bcnt      <= '0;
      sa        <= 1'b1;
      sb        <= 1'b1;
      dsh       <= '0;
      par_bit   <= 1'b0;
      ferr      <= 1'b0;
      wr_en     <= 1'b0;
      wr_ent    <= '0;
      break_det <= 1'b0;
    end else begin
      wr_en     <= push;
      break_det <= brk;
      if (push) wr_ent <= {frame_bad, perr, dsh};
      if (tick) begin
        if (state_n == IDLE || state_n == BRK_WAIT)
          sub <= '0;
        else if (state == IDLE)
          sub <= SW'(1);
        else if (sub == SW'(OVS - 1))
          sub <= '0;
        else
          sub <= sub + 1'b1;
        if (state_n != state)
          bcnt <= '0;
        else if (last && (state == DATA || state == STOP))
          bcnt <= bcnt + 1'b1;
        if (state == IDLE) begin
          par_bit <= 1'b0;
          ferr    <= 1'b0;
        end
        if (sub == SW'(OVS/2 - 1)) sa <= rxs;
        if (sub == SW'(OVS/2))     sb <= rxs;
        if (dec) begin
          unique case (1'b1)
            (state == DATA):      dsh <= {maj, dsh[DATA_BITS-1:1]};
            (state == PARITY_ST): par_bit <= maj;
            (state == STOP):      if (!maj) ferr <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  ent_t          mem [FIFO_DEPTH];
  ent_t          head;
  logic          full, do_pop, do_push;

  assign full    = (cnt == (AW+1)'(FIFO_DEPTH));
  assign m_valid = (cnt != '0);
  assign do_pop  = m_valid && m_ready;
  assign do_push = wr_en && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= wr_en && full && !do_pop;
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wr_ent;
  end

  assign head = mem[rp];
  assign {m_err_frame, m_err_parity, m_data} = m_valid ? head : '0;
  assign fifo_count = cnt;

endmodule

// File: doc/uart_rx_ovs.md
UART_RX_OVS -- requirements
Module: uart_rx_ovs

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line rate in bit/s.
REQ-003 SHALL have parameter OVS, default 16, oversampling ticks per bit (even, >=8).
REQ-004 SHALL have parameter DATA_BITS, default 8, data bits per frame (5..9).
REQ-005 SHALL have parameter PARITY, default 2, parity mode (0 none, 1 odd, 2 even).
REQ-006 SHALL have parameter STOP_BITS, default 1, stop bits checked (1 or 2).
REQ-007 SHALL have parameter FIFO_DEPTH, default 8, receive FIFO entries (power of 2, >=2).
REQ-008 SHALL have port clk, input, 1, clock.
REQ-009 SHALL have port reset, input, 1, reset, asynchronous, active-high.
REQ-010 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-011 SHALL have port m_data, output, DATA_BITS, FIFO head data.
REQ-012 SHALL have port m_err_parity, output, 1, parity error flag of FIFO head.
REQ-013 SHALL have port m_err_frame, output, 1, framing error flag of FIFO head.
REQ-014 SHALL have port m_valid, output, 1, FIFO non-empty.
REQ-015 SHALL have port m_ready, input, 1, consumer accepts head.
REQ-016 SHALL have port overrun, output, 1, one-cycle pulse: frame dropped, FIFO full.
REQ-017 SHALL have port break_det, output, 1, one-cycle pulse: line break detected.
REQ-018 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, occupied entries.

Function
REQ-019 rx SHALL pass a 2-flop synchronizer (rxs); flops reset to 1.
REQ-020 Free-running prescaler SHALL emit one-cycle tick every DIV = CLK_FREQ/(BAUD*OVS) clocks; DIV<1 SHALL be an elaboration error.
REQ-021 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BRK_WAIT; all advance only on ticks.
REQ-022 IDLE: tick with rxs=0 -> START, sub-bit counter sub=0 on that tick.
REQ-023 Each bit SHALL span OVS ticks (sub 0..OVS-1); value = majority of samples at sub OVS/2-1, OVS/2, OVS/2+1; decision at sub OVS/2+1.
REQ-024 START decision 1 -> IDLE (glitch, nothing written); 0 -> DATA.
REQ-025 DATA SHALL capture DATA_BITS bits LSB first, then PARITY (if PARITY!=0) else STOP.
REQ-026 Parity error SHALL be set when XOR(data, parity bit) != 1 (odd) or != 0 (even).
REQ-027 STOP: any stop bit decided 0 sets framing error; after last stop decision -> IDLE immediately (no wait for bit end).
REQ-028 Break: stop decided 0 with all data and parity bits 0 -> break_det pulse, no FIFO write, -> BRK_WAIT; BRK_WAIT -> IDLE on first tick with rxs=1.
REQ-029 Non-break frames SHALL be written {err_frame, err_parity, data} on the clock after last stop decision; m_valid rises the following cycle.
REQ-030 FIFO SHALL be first-word-fall-through; pop when m_valid && m_ready.
REQ-031 Write with FIFO full and no pop SHALL drop the frame and pulse overrun; write with full and simultaneous pop SHALL be accepted, count unchanged.
REQ-032 Simultaneous push and pop when non-full SHALL leave fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-033 m_data/m_err_* SHALL hold stable while m_valid && !m_ready.

Reset
REQ-034 reset SHALL asynchronously set state IDLE, prescaler and sub counter 0, FIFO empty, fifo_count 0, m_valid/overrun/break_det 0, m_data/m_err_* 0.
REQ-035 Reset mid-frame SHALL discard the partial frame; first frame after release SHALL receive normally.

Verification
REQ-036 Defaults, send 0xA5, parity 0, stop 1 -> one entry m_data=0xA5, flags 0, fifo_count=1.
REQ-037 Send 0x3C with parity bit 1 (even mode) -> entry 0x3C, m_err_parity=1, m_err_frame=0.
REQ-038 rx low for 4 ticks then high -> no entry, FSM back in IDLE, next 0x55 frame received correctly.
REQ-039 m_ready=0, send 9 frames 0x00..0x08 -> fifo_count=8, one overrun pulse on 9th; drain yields 0x00..0x07 in order.
REQ-040 rx low 12 bit times -> single break_det pulse, no entry; after rx high, 0x81 received correctly.
REQ-041 DATA_BITS=7, PARITY=1, STOP_BITS=2, second stop bit 0 with data 0x41 -> entry 0x41, m_err_frame=1; reset mid-DATA -> all outputs 0.
